// File: rtl/mips32_prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the mips32 program loader.
// The slave modport is the loader; the master modport is the byte source / memory side.
interface mips32_prog_loader_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, in_byte,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_byte,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mips32_prog_loader.sv
// Boot loader for mips32: packs a byte stream into 32-bit words, writes them to
// instruction memory from address 0 and releases the core once HALT_WORD has been written.
//
// state   | meaning
// IDLE    | after reset, waiting for start, core held
// LOAD    | accepting bytes into the word being assembled
// WRITE   | one-cycle write strobe of the assembled word
// RELEASE | one-cycle core_go pulse, hold dropped
// DONE    | HALT_WORD written, core running, waiting for a restart
// ERR     | MAX_WORDS written without HALT_WORD, core held
module mips32_prog_loader #(
  parameter int          ADDR_W     = 10,
  parameter int          MAX_WORDS  = 1024,
  parameter bit          BIG_ENDIAN = 1'b1,
  parameter logic [31:0] HALT_WORD  = 32'hfc000000
) (
  input  logic                clk1,
  input  logic                rst,
  input  logic                start,
  mips32_prog_loader_if.slave bus,
  output logic                core_hold,
  output logic                core_go,
  output logic [ADDR_W:0]     word_count,
  output logic                done,
  output logic                err_overflow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_RELEASE,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [ADDR_W:0] LAST_SLOT = (ADDR_W+1)'(MAX_WORDS - 1);
  localparam logic [ADDR_W:0] WC_ONE    = (ADDR_W+1)'(1);

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  byte_idx;
  logic [1:0]  lane;
  logic [31:0] word;
  logic        xfer;
  logic        restart;
  logic        in_ready;
  logic        mem_we;

  assign xfer    = (state == S_LOAD) && bus.in_valid;
  assign restart = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
  // Big-endian puts the first byte of a word in the top lane.
  assign lane    = BIG_ENDIAN ? ~byte_idx : byte_idx;

  always_ff @(posedge clk1) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (restart) state_nxt = S_LOAD;
      S_LOAD:    if (xfer && byte_idx == 2'd3) state_nxt = S_WRITE;
      S_WRITE: begin
        if (word == HALT_WORD) begin
          state_nxt = S_RELEASE;
        end else if (word_count == LAST_SLOT) begin
          state_nxt = S_ERR;
        end else begin
          state_nxt = S_LOAD;
        end
      end
      S_RELEASE: state_nxt = S_DONE;
      S_DONE:    if (restart) state_nxt = S_LOAD;
      S_ERR:     if (restart) state_nxt = S_LOAD;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      word_count <= '0;
      byte_idx   <= '0;
      word       <= '0;
    end else if (restart) begin
      word_count <= '0;
      byte_idx   <= '0;
    end else if (xfer) begin
      word[{lane, 3'b000} +: 8] <= bus.in_byte;
      byte_idx                  <= byte_idx + 2'd1;
    end else if (state == S_WRITE) begin
      word_count <= word_count + WC_ONE;
    end
  end

  always_comb begin
    in_ready     = 1'b0;
    mem_we       = 1'b0;
    core_go      = 1'b0;
    core_hold    = 1'b1;
    done         = 1'b0;
    err_overflow = 1'b0;
    case (state)
      S_LOAD:    in_ready = 1'b1;
      S_WRITE:   mem_we   = 1'b1;
      S_RELEASE: begin
        core_go   = 1'b1;
        core_hold = 1'b0;
      end
      S_DONE: begin
        done      = 1'b1;
        core_hold = 1'b0;
      end
      S_ERR:     err_overflow = 1'b1;
      default:   ;
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = word_count[ADDR_W-1:0];
  assign bus.mem_wdata = word;

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Randomized bench for mips32_prog_loader: three instances (big-endian, MAX_WORDS=4,
// little-endian) checked against a queue-based model of the expected memory writes.
module tb_mips32_prog_loader;
  localparam logic [31:0] HALT = 32'hfc000000;

  logic clk1 = 1'b0;
  logic rst;
  always #5 clk1 = ~clk1;

  logic        start_s    [3];
  logic        in_valid_s [3];
  logic [7:0]  in_byte_s  [3];
  logic        rdy_o  [3];
  logic        we_o   [3];
  logic        hold_o [3];
  logic        go_o   [3];
  logic        done_o [3];
  logic        err_o  [3];
  logic [31:0] addr_o [3];
  logic [31:0] data_o [3];
  logic [31:0] wc_o   [3];

  logic [10:0] wc0;
  logic [2:0]  wc1;
  logic [10:0] wc2;

  mips32_prog_loader_if #(.ADDR_W(10)) u_if0 ();
  mips32_prog_loader_if #(.ADDR_W(2))  u_if1 ();
  mips32_prog_loader_if #(.ADDR_W(10)) u_if2 ();

  mips32_prog_loader #(.ADDR_W(10), .MAX_WORDS(1024), .BIG_ENDIAN(1'b1)) u_dut0 (
    .clk1(clk1), .rst(rst), .start(start_s[0]), .bus(u_if0.slave),
    .core_hold(hold_o[0]), .core_go(go_o[0]), .word_count(wc0),
    .done(done_o[0]), .err_overflow(err_o[0])
  );
  mips32_prog_loader #(.ADDR_W(2), .MAX_WORDS(4), .BIG_ENDIAN(1'b1)) u_dut1 (
    .clk1(clk1), .rst(rst), .start(start_s[1]), .bus(u_if1.slave),
    .core_hold(hold_o[1]), .core_go(go_o[1]), .word_count(wc1),
    .done(done_o[1]), .err_overflow(err_o[1])
  );
  mips32_prog_loader #(.ADDR_W(10), .MAX_WORDS(1024), .BIG_ENDIAN(1'b0)) u_dut2 (
    .clk1(clk1), .rst(rst), .start(start_s[2]), .bus(u_if2.slave),
    .core_hold(hold_o[2]), .core_go(go_o[2]), .word_count(wc2),
    .done(done_o[2]), .err_overflow(err_o[2])
  );

  assign u_if0.in_valid = in_valid_s[0];
  assign u_if0.in_byte  = in_byte_s[0];
  assign u_if1.in_valid = in_valid_s[1];
  assign u_if1.in_byte  = in_byte_s[1];
  assign u_if2.in_valid = in_valid_s[2];
  assign u_if2.in_byte  = in_byte_s[2];

  assign rdy_o[0]  = u_if0.in_ready;
  assign rdy_o[1]  = u_if1.in_ready;
  assign rdy_o[2]  = u_if2.in_ready;
  assign we_o[0]   = u_if0.mem_we;
  assign we_o[1]   = u_if1.mem_we;
  assign we_o[2]   = u_if2.mem_we;
  assign addr_o[0] = 32'(u_if0.mem_addr);
  assign addr_o[1] = 32'(u_if1.mem_addr);
  assign addr_o[2] = 32'(u_if2.mem_addr);
  assign data_o[0] = u_if0.mem_wdata;
  assign data_o[1] = u_if1.mem_wdata;
  assign data_o[2] = u_if2.mem_wdata;
  assign wc_o[0]   = 32'(wc0);
  assign wc_o[1]   = 32'(wc1);
  assign wc_o[2]   = 32'(wc2);

  // Observed memory writes and core_go pulses, one record per cycle, sampled mid-cycle.
  int          cyc = 0;
  logic [63:0] wq [3][$];
  int          gocnt  [3] = '{0, 0, 0};
  int          go_cyc [3] = '{0, 0, 0};
  int          we_cyc [3] = '{0, 0, 0};
  int          viol   [3] = '{0, 0, 0};

  always @(negedge clk1) begin
    for (int k = 0; k < 3; k++) begin
      if (we_o[k]) begin
        wq[k].push_back({addr_o[k], data_o[k]});
        we_cyc[k] = cyc;
        if (rdy_o[k]) viol[k]++;
      end
      if (go_o[k]) begin
        gocnt[k]++;
        go_cyc[k] = cyc;
        if (hold_o[k]) viol[k]++;
      end
    end
    cyc++;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Stimulus bytes and model results.
  logic [7:0]  bq [$];
  logic [63:0] ew [$];
  bit          exp_go;
  bit          exp_err;
  int          exp_acc;

  task automatic push_word(input logic [31:0] w, input bit be);
    if (be) begin
      bq.push_back(w[31:24]); bq.push_back(w[23:16]);
      bq.push_back(w[15:8]);  bq.push_back(w[7:0]);
    end else begin
      bq.push_back(w[7:0]);   bq.push_back(w[15:8]);
      bq.push_back(w[23:16]); bq.push_back(w[31:24]);
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == HALT) w = w ^ 32'h1;
    return w;
  endfunction

  // Expected writes: whole words in stream order, stopping after HALT or after maxw words.
  task automatic model(input bit be, input int maxw);
    logic [31:0] w;
    ew.delete();
    exp_go  = 0;
    exp_err = 0;
    for (int i = 0; i < bq.size() / 4; i++) begin
      w = be ? {bq[4*i], bq[4*i+1], bq[4*i+2], bq[4*i+3]}
             : {bq[4*i+3], bq[4*i+2], bq[4*i+1], bq[4*i]};
      ew.push_back({32'(i), w});
      if (w == HALT) begin
        exp_go = 1;
        break;
      end
      if (i + 1 == maxw) begin
        exp_err = 1;
        break;
      end
    end
    exp_acc = (exp_go || exp_err) ? 4 * ew.size() : bq.size();
  endtask

  task automatic pulse_start(input int k);
    @(posedge clk1); #1;
    start_s[k] = 1'b1;
    @(posedge clk1); #1;
    start_s[k] = 1'b0;
  endtask

  // Valid/ready source: once valid is raised the byte is held until accepted.
  task automatic send(input int k, input bit toggle, input int budget, output int nsent);
    int cnt = 0;
    int i   = 0;
    bit v   = 0;
    bit rp  = 0;
    while (cnt < budget) begin
      @(posedge clk1); #1;
      cnt++;
      if (v && rp) begin
        i++;
        v = 0;
      end
      if (i >= bq.size()) break;
      if (!v) v = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid_s[k] = v;
      in_byte_s[k]  = bq[i];
      rp            = rdy_o[k];
    end
    in_valid_s[k] = 1'b0;
    nsent = i;
  endtask

  task automatic run_load(input int k, input bit toggle, input bit be, input int maxw);
    int base_w, base_g, base_v, nsent;
    model(be, maxw);
    base_w = wq[k].size();
    base_g = gocnt[k];
    base_v = viol[k];
    pulse_start(k);
    @(negedge clk1);
    chk("start_ready", 64'(rdy_o[k]), 64'd1);
    chk("start_hold", 64'(hold_o[k]), 64'd1);
    chk("start_wc", 64'(wc_o[k]), 64'd0);
    chk("start_done", 64'(done_o[k]), 64'd0);
    chk("start_err", 64'(err_o[k]), 64'd0);
    send(k, toggle, 12 * bq.size() + 60, nsent);
    chk("accepted", 64'(nsent), 64'(exp_acc));
    repeat (8) @(posedge clk1);
    @(negedge clk1);
    chk("n_writes", 64'(wq[k].size() - base_w), 64'(ew.size()));
    for (int i = 0; i < ew.size() && base_w + i < wq[k].size(); i++)
      chk("write", wq[k][base_w+i], ew[i]);
    chk("n_go", 64'(gocnt[k] - base_g), 64'(exp_go));
    if (exp_go) chk("go_latency", 64'(go_cyc[k] - we_cyc[k]), 64'd1);
    chk("done", 64'(done_o[k]), 64'(exp_go));
    chk("err", 64'(err_o[k]), 64'(exp_err));
    chk("hold", 64'(hold_o[k]), 64'(!exp_go));
    chk("ready_end", 64'(rdy_o[k]), 64'd0);
    chk("wc_end", 64'(wc_o[k]), 64'(ew.size()));
    chk("protocol", 64'(viol[k] - base_v), 64'd0);
  endtask

  task automatic chk_reset(input int k);
    chk("rst_ready", 64'(rdy_o[k]), 64'd0);
    chk("rst_hold", 64'(hold_o[k]), 64'd1);
    chk("rst_we", 64'(we_o[k]), 64'd0);
    chk("rst_go", 64'(go_o[k]), 64'd0);
    chk("rst_done", 64'(done_o[k]), 64'd0);
    chk("rst_err", 64'(err_o[k]), 64'd0);
    chk("rst_wc", 64'(wc_o[k]), 64'd0);
    chk("rst_addr", 64'(addr_o[k]), 64'd0);
    chk("rst_wdata", 64'(data_o[k]), 64'd0);
  endtask

  logic [31:0] prog [11];

  initial begin
    int base_w, nsent, n;
    prog = '{32'h2809000a, 32'h2801000a, 32'h28020019, 32'h28030014, 32'h0ce77800,
             32'h0ce77800, 32'h00432000, 32'h0ce77800, 32'h00832800, 32'h10623000,
             32'hfc000000};
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start_s[k]    = 1'b0;
      in_valid_s[k] = 1'b0;
      in_byte_s[k]  = 8'h00;
    end
    repeat (3) @(posedge clk1);
    @(negedge clk1);
    for (int k = 0; k < 3; k++) chk_reset(k);
    @(posedge clk1); #1;
    rst = 1'b0;

    // Reference program, steady stream, then again with gaps (restart from DONE).
    bq.delete();
    foreach (prog[i]) push_word(prog[i], 1'b1);
    run_load(0, 1'b0, 1'b1, 1024);
    run_load(0, 1'b1, 1'b1, 1024);

    // Overflow with five non-HALT words, then HALT exactly in the last slot.
    bq.delete();
    for (int i = 0; i < 5; i++) push_word(rand_word(), 1'b1);
    run_load(1, 1'b1, 1'b1, 4);
    bq.delete();
    for (int i = 0; i < 3; i++) push_word(rand_word(), 1'b1);
    push_word(HALT, 1'b1);
    run_load(1, 1'b0, 1'b1, 4);

    // Little-endian lane order.
    bq = {8'h0a, 8'h00, 8'h09, 8'h28, 8'h00, 8'h00, 8'h00, 8'hfc};
    run_load(2, 1'b0, 1'b0, 1024);

    // Random programs on every instance.
    for (int r = 0; r < 4; r++) begin
      bq.delete();
      n = $urandom_range(0, 12);
      for (int i = 0; i < n; i++) push_word(rand_word(), 1'b1);
      push_word(HALT, 1'b1);
      run_load(0, 1'b1, 1'b1, 1024);

      bq.delete();
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) push_word(rand_word(), 1'b1);
      if (n <= 3) push_word(HALT, 1'b1);
      run_load(1, 1'($urandom_range(0, 1)), 1'b1, 4);

      bq.delete();
      n = $urandom_range(0, 12);
      for (int i = 0; i < n; i++) push_word(rand_word(), 1'b0);
      push_word(HALT, 1'b0);
      run_load(2, 1'b1, 1'b0, 1024);
    end

    // Reset in the middle of a word: partial word dropped, next load restarts at 0.
    base_w = wq[0].size();
    pulse_start(0);
    bq = {8'h28, 8'h09};
    send(0, 1'b0, 50, nsent);
    chk("partial_sent", 64'(nsent), 64'd2);
    repeat (3) @(posedge clk1);
    #1;
    rst = 1'b1;
    @(posedge clk1);
    @(negedge clk1);
    chk_reset(0);
    chk("partial_no_write", 64'(wq[0].size() - base_w), 64'd0);
    @(posedge clk1); #1;
    rst = 1'b0;
    pulse_start(0);
    bq.delete();
    push_word(32'h2801000a, 1'b1);
    send(0, 1'b0, 60, nsent);
    repeat (3) @(posedge clk1);
    @(negedge clk1);
    chk("restart_n_writes", 64'(wq[0].size() - base_w), 64'd1);
    if (wq[0].size() > base_w) chk("restart_write", wq[0][base_w], {32'd0, 32'h2801000a});
    chk("restart_ready", 64'(rdy_o[0]), 64'd1);
    chk("restart_wc", 64'(wc_o[0]), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
